// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants used by the byte FIFO, its bus
//                interface and the transmit engine integration.
//  Contents    : UART_DATA_W            - width of one UART character
//                UART_TXFIFO_DEPTH_DEF  - default FIFO depth (entries)
//                UART_TXFIFO_AE_DEF     - default almost-empty threshold
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_W           = 8;
   localparam int UART_TXFIFO_DEPTH_DEF = 16;
   localparam int UART_TXFIFO_AE_DEF    = 2;

   // Width of a fill counter able to hold 0..depth inclusive.
   function automatic int fifo_count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Handshake/status bundle of the UART byte FIFO.
//  Signals     : clr, push, push_data      - producer side (bus registers)
//                out_valid/out_data/out_ready - consumer handshake
//                full, count, almost_empty, overflow - status
//  Modports    : master - the logic around the FIFO (producer + consumer)
//                slave  - the FIFO itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_TXFIFO_DEPTH_DEF
) ();

   logic                          clr;
   logic                          push;
   logic [UART_DATA_W-1:0]        push_data;
   logic                          full;
   logic                          out_valid;
   logic [UART_DATA_W-1:0]        out_data;
   logic                          out_ready;
   logic [fifo_count_w(DEPTH)-1:0] count;
   logic                          almost_empty;
   logic                          overflow;

   modport master (
      output clr, push, push_data, out_ready,
      input  full, out_valid, out_data, count, almost_empty, overflow
   );

   modport slave (
      input  clr, push, push_data, out_ready,
      output full, out_valid, out_data, count, almost_empty, overflow
   );

endinterface : uart_tx_fifo_if
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Register-based byte FIFO with valid/ready drain side, fill
//                count, almost-empty level and sticky overflow flag. Nothing
//                here is direction specific, so the RX path can reuse it.
//  Ports       : HCLK    - clock, rising edge
//                HRESET  - synchronous active-high reset
//                bus     - uart_tx_fifo_if.slave (push/pop/status bundle)
//  Parameters  : DEPTH   - entries, power of two 2..256
//                AE_LVL  - almost_empty when count <= AE_LVL (0..DEPTH-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_TXFIFO_DEPTH_DEF,
   parameter int AE_LVL = UART_TXFIFO_AE_DEF
) (
   input  wire logic       HCLK,
   input  wire logic       HRESET,
   uart_tx_fifo_if.slave   bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = fifo_count_w(DEPTH);

   localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0] C_AE_LVL = CW'(AE_LVL);
   localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
   localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [UART_DATA_W-1:0] mem_d [DEPTH];
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   overflow_q, overflow_d;

   logic                   full;
   logic                   not_empty;
   logic                   pop;
   logic                   push_ok;

   assign full      = (count_q == C_DEPTH);
   assign not_empty = (count_q != '0);

   always_comb begin
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      pop     = not_empty & bus.out_ready;
      // A pop in the same cycle frees the slot a full FIFO needs.
      push_ok = bus.push & (~full | pop);

      if (bus.clr) begin
         // Flush wins over any concurrent push or pop.
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
         end
         if (push_ok) begin
            mem_d[wr_ptr_q] = bus.push_data;
            wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
         end
         if (bus.push && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (push_ok && !pop) begin
            count_d = count_q + C_CNT_ONE;
         end else if (pop && !push_ok) begin
            count_d = count_q - C_CNT_ONE;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      // Storage is deliberately left out of reset.
      mem_q <= mem_d;
      if (HRESET) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Head byte is read straight from the array so it is presented before
   // the pop and stays put while the consumer stalls.
   assign bus.out_data     = mem_q[rd_ptr_q];
   assign bus.out_valid    = not_empty;
   assign bus.full         = full;
   assign bus.count        = count_q;
   assign bus.almost_empty = (count_q <= C_AE_LVL);
   assign bus.overflow     = overflow_q;

endmodule : uart_tx_fifo
`default_nettype wire
